dual_product_accumulator: RTL and testbench
===========================================

Name: dual_product_accumulator

Overview:
- Downstream consumer of the 4-lane 16-bit demultiplexer in the Multiplier datapath.
- Collects one word from each lane (A, B, C, D) into operand registers, in any order.
- Once all four are held, computes A*B + C*D with a sequential shift-add engine that runs both products in parallel.
- Presents the sum on a valid/ready output handshake.

Parameters:
- WIDTH, 16, operand width of each lane. Result width is 2*WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- lane_a  input  WIDTH  demux lane A word
- lane_b  input  WIDTH  demux lane B word
- lane_c  input  WIDTH  demux lane C word
- lane_d  input  WIDTH  demux lane D word
- lane_valid  input  4  per-lane strobe, bit0=A … bit3=D, sampled with the lane data
- load_ready  output  1  high when lane loads are accepted
- loaded_mask  output  4  lanes currently captured
- result  output  2*WIDTH+1  A*B + C*D
- result_valid  output  1  result is held and valid
- result_ready  input  1  downstream accepts result

Behaviour:
- Reset values:
  - Clock and reset: clk and rst_n as named above; rst_n is asynchronous and active-low.
  - While rst_n is low: state=IDLE, all operand registers=0, loaded_mask=0, result=0, result_valid=0, load_ready=1.
- States:
  - IDLE/LOAD: load_ready=1. Each clk edge with lane_valid[i]=1 captures lane i and sets loaded_mask[i].
    - Several bits may be set in one cycle; all flagged lanes load.
    - Loading a lane already in loaded_mask overwrites it; no error.
    - When loaded_mask would become 4'b1111 after this edge, go to MUL with iteration counter=0.
  - MUL: load_ready=0 and lane_valid is ignored.
    - Each cycle examines multiplier bit counter of B and D. If set, add A<<counter to acc_ab and C<<counter to acc_cd.
    - Runs exactly WIDTH cycles; counter goes 0..WIDTH-1, then go to SUM.
  - SUM: one cycle. result <= acc_ab + acc_cd (2*WIDTH+1 bits, no overflow possible). Go to DONE.
  - DONE: result_valid=1 and result held stable.
    - On the edge with result_ready=1: clear result_valid, loaded_mask, acc_ab and acc_cd; go to IDLE.
    - Operand registers keep their values but are marked unloaded.
    - load_ready stays 0 in DONE, so a new load starts the cycle after the handshake.
- Latency: result_valid rises WIDTH+2 clk edges after the edge that captured the last lane; 18 edges for WIDTH=16.
- Arithmetic: unsigned by default. Accumulators are 2*WIDTH bits; the sum is zero-extended to 2*WIDTH+1.
- Boundaries:
  - All lanes 0: result=0, same latency.
  - result_ready high before DONE has no effect.
  - rst_n asserted in any state, including mid-MUL: immediate return to reset values; partial products are discarded.
  - lane_valid=4'b0000: no change.

Optional Feature:
- Macro: DUAL_PRODUCT_SIGNED_EN.
- Defined: operands are WIDTH-bit two's complement.
  - During the load-to-MUL transition each operand is replaced by its magnitude, and a sign flag per product (sign A xor sign B, sign C xor sign D) is registered.
  - In SUM, each product is negated when its flag is set, then the two are added as signed 2*WIDTH+1-bit values.
  - Latency is unchanged.
- Undefined: unsigned operation; no sign logic is synthesised.

Test Plan:
- Load A=3, B=5, C=7, D=11 one lane per cycle -> result=92 (0x5C), result_valid rises 18 cycles after the D load, loaded_mask steps 0001→0011→0111→1111.
- Load all lanes 0xFFFF in one cycle (lane_valid=1111) -> result=0x1_FFFC_0002.
- Load D=2, C=4, B=6, then A=9, then A=10 overwriting, holding B until last -> result=10*6+4*2=68 (0x44).
- Hold result_ready=0 for 10 cycles in DONE while driving lane_valid=1111 -> result stable, load_ready=0, loaded_mask unchanged. Then result_ready=1 for one cycle -> result_valid=0, loaded_mask=0 and load_ready=1 on the next cycle.
- Assert rst_n=0 for one cycle at MUL counter=7 -> all outputs at reset values, state IDLE. Then load 1,1,1,1 -> result=2.
- With DUAL_PRODUCT_SIGNED_EN: A=-2 (0xFFFE), B=3, C=4, D=-5 (0xFFFB) -> result=-26 (0x1_FFFF_FFE6).

Source files
------------

// File: rtl/dual_product_accumulator.sv
// Collects four lane words and computes A*B + C*D with two parallel shift-add multipliers.
// Optional two's-complement operation is enabled by defining DUAL_PRODUCT_SIGNED_EN.
module dual_product_accumulator #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   lane_a,
    input  logic [WIDTH-1:0]   lane_b,
    input  logic [WIDTH-1:0]   lane_c,
    input  logic [WIDTH-1:0]   lane_d,
    input  logic [3:0]         lane_valid,
    output logic               load_ready,
    output logic [3:0]         loaded_mask,
    output logic [2*WIDTH:0]   result,
    output logic               result_valid,
    input  logic               result_ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = 2 * WIDTH;
    localparam int RW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SUM,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opA_q, opA_d, opB_q, opB_d, opC_q, opC_d, opD_q, opD_d;
    logic [3:0]        mask_q, mask_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     accAb_q, accAb_d, accCd_q, accCd_d;
    logic [RW-1:0]     result_q, result_d;
`ifdef DUAL_PRODUCT_SIGNED_EN
    logic              sgnAb_q, sgnAb_d, sgnCd_q, sgnCd_d;
    logic [RW-1:0]     prodAb, prodCd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            opC_q    <= '0;
            opD_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            accAb_q  <= '0;
            accCd_q  <= '0;
            result_q <= '0;
`ifdef DUAL_PRODUCT_SIGNED_EN
            sgnAb_q  <= 1'b0;
            sgnCd_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            opC_q    <= opC_d;
            opD_q    <= opD_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            accAb_q  <= accAb_d;
            accCd_q  <= accCd_d;
            result_q <= result_d;
`ifdef DUAL_PRODUCT_SIGNED_EN
            sgnAb_q  <= sgnAb_d;
            sgnCd_q  <= sgnCd_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        opC_d    = opC_q;
        opD_d    = opD_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        accAb_d  = accAb_q;
        accCd_d  = accCd_q;
        result_d = result_q;
`ifdef DUAL_PRODUCT_SIGNED_EN
        sgnAb_d  = sgnAb_q;
        sgnCd_d  = sgnCd_q;
        prodAb   = '0;
        prodCd   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (lane_valid[0]) opA_d = lane_a;
                if (lane_valid[1]) opB_d = lane_b;
                if (lane_valid[2]) opC_d = lane_c;
                if (lane_valid[3]) opD_d = lane_d;
                mask_d = mask_q | lane_valid;
                if (mask_d == 4'hF) begin
                    state_d = MUL;
                    cnt_d   = '0;
`ifdef DUAL_PRODUCT_SIGNED_EN
                    // Multiply magnitudes; the product signs are restored in SUM.
                    sgnAb_d = opA_d[WIDTH-1] ^ opB_d[WIDTH-1];
                    sgnCd_d = opC_d[WIDTH-1] ^ opD_d[WIDTH-1];
                    if (opA_d[WIDTH-1]) opA_d = ~opA_d + WIDTH'(1);
                    if (opB_d[WIDTH-1]) opB_d = ~opB_d + WIDTH'(1);
                    if (opC_d[WIDTH-1]) opC_d = ~opC_d + WIDTH'(1);
                    if (opD_d[WIDTH-1]) opD_d = ~opD_d + WIDTH'(1);
`endif
                end
            end
            MUL: begin
                if (opB_q[cnt_q]) accAb_d = accAb_q + ({{WIDTH{1'b0}}, opA_q} << cnt_q);
                if (opD_q[cnt_q]) accCd_d = accCd_q + ({{WIDTH{1'b0}}, opC_q} << cnt_q);
                if (cnt_q == CW'(WIDTH - 1)) state_d = SUM;
                else                         cnt_d   = cnt_q + CW'(1);
            end
            SUM: begin
`ifdef DUAL_PRODUCT_SIGNED_EN
                prodAb   = sgnAb_q ? (~{1'b0, accAb_q} + RW'(1)) : {1'b0, accAb_q};
                prodCd   = sgnCd_q ? (~{1'b0, accCd_q} + RW'(1)) : {1'b0, accCd_q};
                result_d = prodAb + prodCd;
`else
                result_d = {1'b0, accAb_q} + {1'b0, accCd_q};
`endif
                state_d  = DONE;
            end
            DONE: begin
                // Operands are kept but marked unloaded so a new set must be captured.
                if (result_ready) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    accAb_d = '0;
                    accCd_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_ready   = (state_q == IDLE);
    assign loaded_mask  = mask_q;
    assign result       = result_q;
    assign result_valid = (state_q == DONE);

endmodule

// File: tb/tb_dual_product_accumulator.sv
// Directed table-driven bench for dual_product_accumulator; expected values are hand-computed
// for both the unsigned build and the DUAL_PRODUCT_SIGNED_EN build.
module tb_dual_product_accumulator;

    localparam int WIDTH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WIDTH-1:0]  lane_a, lane_b, lane_c, lane_d;
    logic [3:0]        lane_valid;
    logic              load_ready;
    logic [3:0]        loaded_mask;
    logic [2*WIDTH:0]  result;
    logic              result_valid;
    logic              result_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a, b, c, d;
        logic [32:0] expU;
        logic [32:0] expS;
    } vec_t;

    vec_t vecs[5];

    dual_product_accumulator #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lane_a       (lane_a),
        .lane_b       (lane_b),
        .lane_c       (lane_c),
        .lane_d       (lane_d),
        .lane_valid   (lane_valid),
        .load_ready   (load_ready),
        .loaded_mask  (loaded_mask),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] pick(input logic [32:0] u, input logic [32:0] s);
`ifdef DUAL_PRODUCT_SIGNED_EN
        return s;
`else
        return u;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
        lane_a = a;
        lane_b = b;
        lane_c = c;
        lane_d = d;
        lane_valid = v;
        tick();
        lane_valid = 4'b0000;
    endtask

    // Called right after the capture edge; that edge counts as the first of the latency.
    task automatic waitResult(input string name, input logic [32:0] exp);
        int n;
        n = 1;
        while (!result_valid && n < 100) begin
            tick();
            n++;
        end
        checkOutput({name, " latency"}, 64'(n), 64'(18));
        checkOutput({name, " result"}, 64'(result), 64'(exp));
    endtask

    task automatic drainResult(input string name);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checkOutput({name, " valid cleared"}, 64'(result_valid), 64'(0));
        checkOutput({name, " mask cleared"}, 64'(loaded_mask), 64'(0));
        checkOutput({name, " load_ready"}, 64'(load_ready), 64'(1));
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 33'h1_FFFC_0002, 33'h0_0000_0002};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 33'h0,           33'h0};
        vecs[2] = '{16'h1234, 16'h0002, 16'h0100, 16'h0100, 33'h0_0001_2468, 33'h0_0001_2468};
        vecs[3] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h0001, 33'h0_4000_FFFF, 33'h0_3FFF_FFFF};
        vecs[4] = '{16'hFFFE, 16'h0003, 16'h0004, 16'hFFFB, 33'h0_0006_FFE6, 33'h1_FFFF_FFE6};

        rst_n = 1'b0;
        lane_a = '0; lane_b = '0; lane_c = '0; lane_d = '0;
        lane_valid = 4'b0000;
        result_ready = 1'b0;
        #3;
        checkOutput("reset load_ready", 64'(load_ready), 64'(1));
        checkOutput("reset mask", 64'(loaded_mask), 64'(0));
        checkOutput("reset result", 64'(result), 64'(0));
        checkOutput("reset valid", 64'(result_valid), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // One lane per cycle with the mask stepping up.
        applyStimulus(4'b0000, 16'd99, 16'd99, 16'd99, 16'd99);
        checkOutput("idle no change mask", 64'(loaded_mask), 64'(0));
        applyStimulus(4'b0001, 16'd3, 16'd0, 16'd0, 16'd0);
        checkOutput("step mask A", 64'(loaded_mask), 64'(4'b0001));
        applyStimulus(4'b0010, 16'd0, 16'd5, 16'd0, 16'd0);
        checkOutput("step mask B", 64'(loaded_mask), 64'(4'b0011));
        applyStimulus(4'b0100, 16'd0, 16'd0, 16'd7, 16'd0);
        checkOutput("step mask C", 64'(loaded_mask), 64'(4'b0111));
        applyStimulus(4'b1000, 16'd0, 16'd0, 16'd0, 16'd11);
        checkOutput("step mask D", 64'(loaded_mask), 64'(4'b1111));
        checkOutput("step load_ready MUL", 64'(load_ready), 64'(0));
        waitResult("step", 33'd92);
        drainResult("step");

        // Table of all-lanes-at-once loads; vector 2 holds result_ready high before DONE.
        for (int i = 0; i < 5; i++) begin
            result_ready = (i == 2);
            applyStimulus(4'b1111, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            checkOutput($sformatf("vec%0d mask", i), 64'(loaded_mask), 64'(4'b1111));
            waitResult($sformatf("vec%0d", i), pick(vecs[i].expU, vecs[i].expS));
            drainResult($sformatf("vec%0d", i));
        end

        // Out-of-order loads with an overwrite of A, B arriving last.
        applyStimulus(4'b1000, 16'd0, 16'd0, 16'd0, 16'd2);
        applyStimulus(4'b0100, 16'd0, 16'd0, 16'd4, 16'd0);
        applyStimulus(4'b0001, 16'd9, 16'd0, 16'd0, 16'd0);
        applyStimulus(4'b0001, 16'd10, 16'd0, 16'd0, 16'd0);
        checkOutput("ovr mask", 64'(loaded_mask), 64'(4'b1101));
        applyStimulus(4'b0010, 16'd0, 16'd6, 16'd0, 16'd0);
        waitResult("ovr", 33'd68);

        // DONE holds the result while loads are offered and not accepted.
        lane_a = 16'd1; lane_b = 16'd1; lane_c = 16'd1; lane_d = 16'd1;
        lane_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput($sformatf("hold%0d result", k), 64'(result), 64'(68));
            checkOutput($sformatf("hold%0d valid", k), 64'(result_valid), 64'(1));
            checkOutput($sformatf("hold%0d load_ready", k), 64'(load_ready), 64'(0));
            checkOutput($sformatf("hold%0d mask", k), 64'(loaded_mask), 64'(4'b1111));
        end
        lane_valid = 4'b0000;
        drainResult("hold");

        // Asynchronous reset with the multiplier counter at 7.
        applyStimulus(4'b1111, 16'd3, 16'd5, 16'd7, 16'd11);
        for (int k = 0; k < 7; k++) tick();
        checkOutput("mid counter", 64'(dut.cnt_q), 64'(7));
        rst_n = 1'b0;
        #2;
        checkOutput("midrst load_ready", 64'(load_ready), 64'(1));
        checkOutput("midrst mask", 64'(loaded_mask), 64'(0));
        checkOutput("midrst result", 64'(result), 64'(0));
        checkOutput("midrst valid", 64'(result_valid), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("postrst load_ready", 64'(load_ready), 64'(1));
        applyStimulus(4'b1111, 16'd1, 16'd1, 16'd1, 16'd1);
        waitResult("postrst", 33'd2);
        drainResult("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
